serial_subtractor_16bit: RTL and testbench
==========================================

Name: serial_subtractor_16bit

Overview:
- Sequential bit-serial two's-complement subtractor. Computes diff = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first.
- Uses a single full-subtractor cell in place of the parallel ripple-carry adder chain.
- Sits beside the 16-bit RCA in the arithmetic library for area-constrained datapaths.
- Valid/ready handshakes on both the input and the output side.

Parameters:
- WIDTH, 16, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow out of the MSB; 1 iff a < b + bin (unsigned).
- ovf  output  1  signed overflow of the subtraction.

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high on rst, sampled at the rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, bit counter=0, borrow register=0.

State machine (states IDLE, RUN, DONE):
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: capture a, b into shift registers, load borrow register with bin, capture a[MSB] and b[MSB] for ovf, clear the bit counter, go to RUN.
- RUN:
  - in_ready=0, out_valid=0. Any in_valid during RUN is ignored.
  - Each edge processes bit i = counter:
    - d = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d shifts into the MSB of the partial-result register. Operand registers shift right. Counter increments.
  - On the edge that processes bit WIDTH-1:
    - load diff with the completed result.
    - bout = br_next.
    - ovf = (a_msb != b_msb) & (result_msb != a_msb).
    - go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - diff, bout, ovf are held stable.
  - On an edge with out_ready=1, go to IDLE. Output registers keep their values until the next completion.

Latency and throughput:
- Operation accepted at edge E0. out_valid is high after edge E0+WIDTH, i.e. 16 cycles for the default.
- Minimum spacing between accepts is WIDTH+2 cycles when out_ready is held at 1.

Output rules:
- diff, bout, ovf change only on the RUN->DONE transition or on reset. Partial results are never visible on diff.

Boundary conditions:
- Borrow chain: bin=1 propagates through the chain exactly like an incoming borrow.
- Wrap-around: diff is modulo 2^WIDTH.
- Reset mid-RUN or in DONE: the in-flight operation is discarded and all reset values apply on the next cycle.
- rst together with in_valid: rst wins and nothing is captured.
- Operand inputs are only sampled at the accept edge. Later changes to a, b, bin have no effect.

Test Plan:
1. Basic subtraction: a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0. out_valid rises exactly 16 cycles after the accept edge. in_ready=0 throughout.
2. Underflow: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0.
3. Signed overflow, both directions:
   - a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1.
   - a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
4. Borrow-in: a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1, ovf=0. Also a=0xFFFF, b=0x0000, bin=1 -> diff=0xFFFE, bout=0.
5. Backpressure and ignored input:
   - Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and diff/bout/ovf stay stable.
   - Toggle in_valid and operands during RUN/DONE -> no effect on the result.
   - Release out_ready -> in_ready=1 on the next cycle.
   - Back-to-back ops with out_ready=1 -> accepts spaced WIDTH+2 cycles apart.
6. Reset mid-operation: assert rst for 1 cycle at the 8th RUN cycle of a=0xAAAA, b=0x5555 -> next cycle in_ready=1, out_valid=0, diff=0, bout=0, ovf=0. A following op a=0x0010, b=0x0001 -> diff=0x000F, bout=0.

Source files
------------

// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit
//   Bit-serial two's-complement subtractor: diff = a - b - bin, evaluated one
//   bit per clock, LSB first, through a single full-subtractor cell.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a, b, bin valid
//   in_ready   block can accept an operation (IDLE)
//   a, b       minuend / subtrahend, WIDTH bits
//   bin        borrow in
//   out_valid  result valid (DONE)
//   out_ready  downstream accepts the result
//   diff       a - b - bin modulo 2^WIDTH
//   bout       borrow out of the MSB (a < b + bin, unsigned)
//   ovf        signed overflow of the subtraction
module serial_subtractor_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh, b_sh, part;
    logic [CW-1:0]    cnt;
    logic             br, a_msb, b_msb;
    logic             d, br_next, last;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    always_comb begin
        d       = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            part  <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    part <= {d, part[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    // The final bit is still combinational here, so the
                    // completed result is assembled from d rather than part.
                    if (last) begin
                        diff <= {d, part[WIDTH-1:1]};
                        bout <= br_next;
                        ovf  <= (a_msb != b_msb) && (d != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// tb_serial_subtractor_16bit
//   Directed bench for serial_subtractor_16bit (WIDTH=16): expected results
//   are hand-computed constants.
module tb_serial_subtractor_16bit;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    serial_subtractor_16bit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, scramble inputs during RUN, wait for out_valid,
    // check latency/in_ready/results, then release with out_ready.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vbin, input logic [15:0] ediff,
                          input logic ebout, input logic eovf);
        int cyc;
        logic ir_bad;
        check({tag, ".in_ready_idle"}, in_ready, 1'b1);
        a = va; b = vb; bin = vbin; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        ir_bad = 1'b0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) ir_bad = 1'b1;
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            in_valid = 1'($urandom);
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, cyc, WIDTH);
        check({tag, ".in_ready_busy"}, {31'd0, ir_bad}, 32'd0);
        check({tag, ".in_ready_done"}, in_ready, 1'b0);
        check({tag, ".diff"}, diff, ediff);
        check({tag, ".bout"}, bout, ebout);
        check({tag, ".ovf"}, ovf, eovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".out_valid_rel"}, out_valid, 1'b0);
        check({tag, ".in_ready_rel"}, in_ready, 1'b1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset.in_ready", in_ready, 1'b1);
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.diff", diff, 16'h0000);
        check("reset.bout", bout, 1'b0);
        check("reset.ovf", ovf, 1'b0);

        run_op("basic",    16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("underflow",16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op("ovf_neg",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op("ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_op("bin_eq",   16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("bin_max",  16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // Backpressure: AAAA - 5555 = 5555, signed overflow (neg - pos -> pos).
        a = 16'hAAAA; b = 16'h5555; bin = 1'b0; in_valid = 1'b1;
        tick();
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            in_valid = ~in_valid; a = ~a; b = b + 16'd3; bin = ~bin;
            tick();
            cyc++;
        end
        check("bp.latency", cyc, WIDTH);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
            tick();
            check("bp.out_valid_hold", out_valid, 1'b1);
            check("bp.diff_hold", diff, 16'h5555);
            check("bp.bout_hold", bout, 1'b0);
            check("bp.ovf_hold", ovf, 1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.in_ready_rel", in_ready, 1'b1);
        check("bp.out_valid_rel", out_valid, 1'b0);

        // Back-to-back with in_valid and out_ready held high: in_ready pulses
        // WIDTH+2 cycles apart.
        a = 16'h0003; b = 16'h0001; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        check("b2b.in_ready0", in_ready, 1'b1);
        tick();
        cyc = 1;
        while (!in_ready && cyc < 60) begin
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b.spacing", cyc, WIDTH + 2);
        check("b2b.diff", diff, 16'h0002);
        tick();
        out_ready = 1'b0;
        check("b2b.idle_after", in_ready, 1'b1);

        // Reset mid-RUN: rst sampled at the 8th RUN edge.
        a = 16'hAAAA; b = 16'h5555; bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("midrst.busy", in_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.in_ready", in_ready, 1'b1);
        check("midrst.out_valid", out_valid, 1'b0);
        check("midrst.diff", diff, 16'h0000);
        check("midrst.bout", bout, 1'b0);
        check("midrst.ovf", ovf, 1'b0);
        run_op("after_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);

        // rst together with in_valid: nothing captured.
        a = 16'h0001; b = 16'h0002; in_valid = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_vs_valid.in_ready", in_ready, 1'b1);
        check("rst_vs_valid.out_valid", out_valid, 1'b0);
        check("rst_vs_valid.diff", diff, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
